// File: rtl/gate_truth_table_checker.sv
// gate_truth_table_checker: steps a/b through all four input combinations, samples the
// seven gate outputs after a settle delay and accumulates per-combination/per-gate errors.
module gate_truth_table_checker #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic [6:0] gate_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_vec,
    output logic [6:0] fail_mask
);
    localparam int CNT_W = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           r_state;
    logic [1:0]       r_combo;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [3:0]       r_errVec;
    logic [6:0]       r_failMask;

    logic             w_a;
    logic             w_b;
    logic [6:0]       w_expected;
    logic [6:0]       w_mism;
    logic [6:0]       w_failNext;
    logic             w_sampleEdge;

    // The stimulus is the combo register itself, so a/b are glitch-free registered outputs.
    assign w_a          = r_combo[1];
    assign w_b          = r_combo[0];
    assign w_expected   = {~(w_a ^ w_b), w_a ^ w_b, ~(w_a | w_b), ~(w_a & w_b),
                           ~w_a, w_a | w_b, w_a & w_b};
    assign w_mism       = gate_in ^ w_expected;
    assign w_failNext   = r_failMask | w_mism;
    assign w_sampleEdge = (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_combo    <= 2'd0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_errVec   <= 4'd0;
            r_failMask <= 7'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_busy <= 1'b0;
                    if (start) begin
                        r_state    <= RUN;
                        r_combo    <= 2'd0;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_pass     <= 1'b0;
                        r_errVec   <= 4'd0;
                        r_failMask <= 7'd0;
                    end
                end
                RUN: begin
                    if (w_sampleEdge) begin
                        r_failMask        <= w_failNext;
                        r_errVec[r_combo] <= |w_mism;
                        r_cnt             <= '0;
                        // Last combination: the verdict must include this sample's mismatches.
                        if (r_combo == 2'd3) begin
                            r_state <= IDLE;
                            r_combo <= 2'd0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_failNext == 7'd0);
                        end else begin
                            r_combo <= r_combo + 2'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign a         = w_a;
    assign b         = w_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_vec   = r_errVec;
    assign fail_mask = r_failMask;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// tb_gate_truth_table_checker: three checker instances (S=4, 3, 1) driven by a gate model
// with injectable faults, checked every cycle against a timing-based reference model.
module tb_gate_truth_table_checker;

    localparam int SL [3] = '{4, 3, 1};
    // Truth tables per gate (nibble g, bit c = output for combo c={a,b}), gate 0 in the LSBs.
    localparam logic [27:0] TT = {4'b1001, 4'b0110, 4'b0001, 4'b0111, 4'b0011, 4'b1110, 4'b1000};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] startV = 3'b000;
    logic [2:0] aV, bV, busyV, doneV, passV;
    logic [3:0] errV  [3];
    logic [6:0] failV [3];
    logic [6:0] gate0, gate1, gate2;

    int fault0 = 0;
    int fault2 = 0;
    int cyc = 0;
    int testsRun = 0;
    int testsFailed = 0;
    bit cmpOn = 1'b0;

    int         mK    [3] = '{0, 0, 0};
    bit         mBusy [3] = '{0, 0, 0};
    bit         mDone [3] = '{0, 0, 0};
    bit         mPass [3] = '{0, 0, 0};
    logic [3:0] mErr  [3] = '{4'd0, 4'd0, 4'd0};
    logic [6:0] mFail [3] = '{7'd0, 7'd0, 7'd0};

    gate_truth_table_checker #(.SETTLE_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .start(startV[0]), .a(aV[0]), .b(bV[0]), .gate_in(gate0),
        .busy(busyV[0]), .done(doneV[0]), .pass(passV[0]), .err_vec(errV[0]), .fail_mask(failV[0])
    );
    gate_truth_table_checker #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .start(startV[1]), .a(aV[1]), .b(bV[1]), .gate_in(gate1),
        .busy(busyV[1]), .done(doneV[1]), .pass(passV[1]), .err_vec(errV[1]), .fail_mask(failV[1])
    );
    gate_truth_table_checker #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(startV[2]), .a(aV[2]), .b(bV[2]), .gate_in(gate2),
        .busy(busyV[2]), .done(doneV[2]), .pass(passV[2]), .err_vec(errV[2]), .fail_mask(failV[2])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] goodGate(input int c);
        logic [27:0] tt;
        logic [6:0]  g;
        tt = TT;
        for (int i = 0; i < 7; i++) g[i] = tt[i*4 + c];
        return g;
    endfunction

    // Lane 0 mode 1: xor stuck at 0.  Lane 2 mode 0: not stuck at 1, mode 1: not stuck at 0.
    function automatic logic [6:0] faultyGate(input int lane, input int mode, input int c);
        logic [6:0] g;
        g = goodGate(c);
        if (lane == 0 && mode == 1) g[5] = 1'b0;
        if (lane == 2) g[2] = (mode == 0);
        return g;
    endfunction

    always_comb gate0 = faultyGate(0, fault0, int'({aV[0], bV[0]}));
    always_comb gate1 = goodGate(int'({aV[1], bV[1]})) ^
                        ((mBusy[1] && (mK[1] % 3 == 2)) ? 7'h00 : 7'h7F);
    always_comb gate2 = faultyGate(2, fault2, int'({aV[2], bV[2]}));

    // Reference: mK counts edges since acceptance; every S-th edge samples combo mK/S-1.
    always @(posedge clk) begin
        for (int l = 0; l < 3; l++) begin
            if (rst) begin
                mBusy[l] = 0; mDone[l] = 0; mPass[l] = 0; mK[l] = 0;
                mErr[l] = 4'd0; mFail[l] = 7'd0;
            end else begin
                mDone[l] = 0;
                if (!mBusy[l]) begin
                    if (startV[l]) begin
                        mBusy[l] = 1; mK[l] = 0; mPass[l] = 0;
                        mErr[l] = 4'd0; mFail[l] = 7'd0;
                    end
                end else begin
                    int c;
                    int mode;
                    logic [6:0] mism;
                    mK[l] = mK[l] + 1;
                    if (mK[l] % SL[l] == 0) begin
                        c = mK[l] / SL[l] - 1;
                        mode = (l == 0) ? fault0 : ((l == 2) ? fault2 : 0);
                        mism = faultyGate(l, mode, c) ^ goodGate(c);
                        mErr[l][c] = |mism;
                        mFail[l] = mFail[l] | mism;
                        if (mK[l] == 4 * SL[l]) begin
                            mBusy[l] = 0; mDone[l] = 1; mK[l] = 0;
                            mPass[l] = (mFail[l] == 7'd0);
                        end
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int lane,
                               input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s lane%0d cycle %0d: got %0h, expected %0h",
                     name, lane, cyc, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (cmpOn) begin
            for (int l = 0; l < 3; l++) begin
                int combo;
                combo = mBusy[l] ? mK[l] / SL[l] : 0;
                checkOutput("a", l, 32'(aV[l]), 32'((combo >> 1) & 1));
                checkOutput("b", l, 32'(bV[l]), 32'(combo & 1));
                checkOutput("busy", l, 32'(busyV[l]), 32'(mBusy[l]));
                checkOutput("done", l, 32'(doneV[l]), 32'(mDone[l]));
                checkOutput("pass", l, 32'(passV[l]), 32'(mPass[l]));
                checkOutput("err_vec", l, 32'(errV[l]), 32'(mErr[l]));
                checkOutput("fail_mask", l, 32'(failV[l]), 32'(mFail[l]));
            end
        end
    end

    task automatic applyStimulus(input int lane, input int hold, output int e0);
        @(negedge clk);
        #1 startV[lane] = 1'b1;
        @(posedge clk);
        #1 e0 = cyc;
        repeat (hold) @(posedge clk);
        #1 startV[lane] = 1'b0;
    endtask

    task automatic waitDone(input int lane, input int e0, input int expLat);
        bit found;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (doneV[lane] === 1'b1) found = 1;
        end
        checkOutput("doneSeen", lane, 32'(found), 32'd1);
        if (found) checkOutput("doneLatency", lane, 32'(cyc - e0), 32'(expLat));
    endtask

    task automatic checkResult(input int lane, input logic p, input logic [3:0] ev, input logic [6:0] fm);
        checkOutput("finalPass", lane, 32'(passV[lane]), 32'(p));
        checkOutput("finalErrVec", lane, 32'(errV[lane]), 32'(ev));
        checkOutput("finalFailMask", lane, 32'(failV[lane]), 32'(fm));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d failed so far", testsFailed);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int e0;
        repeat (3) @(posedge clk);
        #1 cmpOn = 1'b1;
        @(negedge clk);
        checkOutput("rstA", 0, 32'(aV[0]), 32'd0);
        checkOutput("rstB", 0, 32'(bV[0]), 32'd0);
        checkOutput("rstBusy", 0, 32'(busyV[0]), 32'd0);
        checkOutput("rstDone", 0, 32'(doneV[0]), 32'd0);
        checkResult(0, 1'b0, 4'b0000, 7'b0000000);
        #1 rst = 1'b0;

        // Healthy gates, S=4: step timing and a clean verdict.
        fault0 = 0;
        applyStimulus(0, 0, e0);
        do @(negedge clk); while (cyc < e0 + 5);
        checkOutput("abAtK5", 0, 32'({aV[0], bV[0]}), 32'b01);
        do @(negedge clk); while (cyc < e0 + 13);
        checkOutput("abAtK13", 0, 32'({aV[0], bV[0]}), 32'b11);
        waitDone(0, e0, 16);
        checkResult(0, 1'b1, 4'b0000, 7'b0000000);

        // xor stuck at 0 fails only where a^b should be 1.
        fault0 = 1;
        applyStimulus(0, 0, e0);
        waitDone(0, e0, 16);
        checkResult(0, 1'b0, 4'b0110, 7'b0100000);

        // S=3 lane: gate outputs are wrong except in each sampling cycle.
        applyStimulus(1, 0, e0);
        waitDone(1, e0, 12);
        checkResult(1, 1'b1, 4'b0000, 7'b0000000);

        // start held during the run, then re-asserted in the done cycle.
        fault0 = 0;
        applyStimulus(0, 6, e0);
        waitDone(0, e0, 16);
        checkOutput("b2bFirstPass", 0, 32'(passV[0]), 32'd1);
        #1 startV[0] = 1'b1;
        @(posedge clk);
        #1 e0 = cyc;
        startV[0] = 1'b0;
        waitDone(0, e0, 16);
        checkOutput("b2bSecondPass", 0, 32'(passV[0]), 32'd1);

        // Mid-run reset after the combo-1 sample has already flagged xor.
        fault0 = 1;
        applyStimulus(0, 0, e0);
        do @(negedge clk); while (cyc < e0 + 8);
        checkOutput("preRstErrVec", 0, 32'(errV[0]), 32'b0010);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abortBusy", 0, 32'(busyV[0]), 32'd0);
        checkOutput("abortAB", 0, 32'({aV[0], bV[0]}), 32'd0);
        checkResult(0, 1'b0, 4'b0000, 7'b0000000);
        #1 rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            checkOutput("noDoneAfterAbort", 0, 32'(doneV[0]), 32'd0);
        end

        // S=1 lane: not(a) stuck at 1 then stuck at 0.
        fault2 = 0;
        applyStimulus(2, 0, e0);
        waitDone(2, e0, 4);
        checkResult(2, 1'b0, 4'b1100, 7'b0000100);
        fault2 = 1;
        applyStimulus(2, 0, e0);
        waitDone(2, e0, 4);
        checkResult(2, 1'b0, 4'b0011, 7'b0000100);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
